// File: rtl/mul4_fitness_pkg.sv
// Shared types, defaults and width helpers for the 2x2 multiplier fitness scorer.
package mul4_fitness_pkg;

  localparam int DEF_LANES     = 16;
  localparam int DEF_BEATS     = 16;
  localparam int MAX_LANE_BITS = 4;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, REPORT} state_t;

  function automatic int bit_w_f(input int lanes, input int beats);
    return $clog2(lanes * MAX_LANE_BITS * beats + 1);
  endfunction

  function automatic int lane_w_f(input int lanes, input int beats);
    return $clog2(lanes * beats + 1);
  endfunction

endpackage

// File: rtl/mul4_lane_checker.sv
// Combinational per-beat scorer: golden 2x2 product per lane, matching-bit and
// fully-correct-lane counts summed across all lanes of one beat.
module mul4_lane_checker
  import mul4_fitness_pkg::*;
#(
  parameter int LANES       = DEF_LANES,
  parameter int CNT_BITS_W  = $clog2(LANES * MAX_LANE_BITS + 1),
  parameter int CNT_LANES_W = $clog2(LANES + 1)
) (
  input  logic [LANES-1:0]       a1,
  input  logic [LANES-1:0]       a0,
  input  logic [LANES-1:0]       b1,
  input  logic [LANES-1:0]       b0,
  input  logic [LANES-1:0]       y3,
  input  logic [LANES-1:0]       y2,
  input  logic [LANES-1:0]       y1,
  input  logic [LANES-1:0]       y0,
  output logic [CNT_BITS_W-1:0]  bits,
  output logic [CNT_LANES_W-1:0] lanes
);

  logic [3:0] w_e;
  logic [3:0] w_y;
  logic [3:0] w_match;
  logic [2:0] w_cnt;

  always_comb begin
    bits    = '0;
    lanes   = '0;
    w_e     = '0;
    w_y     = '0;
    w_match = '0;
    w_cnt   = '0;
    for (int i = 0; i < LANES; i++) begin
      // Zero-extend operands so the product keeps all 4 bits (3*3 = 9).
      w_e     = {2'b00, a1[i], a0[i]} * {2'b00, b1[i], b0[i]};
      w_y     = {y3[i], y2[i], y1[i], y0[i]};
      w_match = ~(w_e ^ w_y);
      w_cnt   = {2'b00, w_match[0]} + {2'b00, w_match[1]}
              + {2'b00, w_match[2]} + {2'b00, w_match[3]};
      bits    = bits + CNT_BITS_W'(w_cnt);
      lanes   = lanes + CNT_LANES_W'(w_match == 4'hF);
    end
  end

endmodule

// File: rtl/mul4_fitness_scorer.sv
// Batch fitness scorer: two-stage (score, accumulate) pipeline under a
// four-state FSM, delivering one score record per batch over valid/ready.
module mul4_fitness_scorer
  import mul4_fitness_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int BEATS  = DEF_BEATS,
  parameter int BIT_W  = bit_w_f(LANES, BEATS),
  parameter int LANE_W = lane_w_f(LANES, BEATS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LANES-1:0]  a1,
  input  logic [LANES-1:0]  a0,
  input  logic [LANES-1:0]  b1,
  input  logic [LANES-1:0]  b0,
  input  logic [LANES-1:0]  y3,
  input  logic [LANES-1:0]  y2,
  input  logic [LANES-1:0]  y1,
  input  logic [LANES-1:0]  y0,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BIT_W-1:0]  bit_score,
  output logic [LANE_W-1:0] lane_score,
  output logic              perfect,
  output logic              busy,
  output state_t            dbg_state
);

  // Handshakes: a beat moves on a cycle with in_valid && in_ready; the record
  // moves on a cycle with out_valid && out_ready. Both readies/valids come
  // straight from the state register and never depend on the partner signal.

  localparam int BB_W  = $clog2(LANES * MAX_LANE_BITS + 1);
  localparam int BL_W  = $clog2(LANES + 1);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BIT_W-1:0] PERFECT_SCORE = BIT_W'(LANES * MAX_LANE_BITS * BEATS);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_in_ready;
  logic                w_out_valid;
  logic                w_xfer;
  logic                w_last_xfer;
  logic                w_start_ok;
  logic [CNT_W-1:0]    r_beat_cnt;
  logic [BB_W-1:0]     w_bits;
  logic [BL_W-1:0]     w_lanes;
  logic [BB_W-1:0]     r_s1_bits;
  logic [BL_W-1:0]     r_s1_lanes;
  logic [BIT_W-1:0]    r_bit_acc;
  logic [LANE_W-1:0]   r_lane_acc;
  logic                r_perfect;
  logic [BIT_W-1:0]    w_bit_acc_nxt;
  logic [LANE_W-1:0]   w_lane_acc_nxt;

  mul4_lane_checker #(
    .LANES       (LANES),
    .CNT_BITS_W  (BB_W),
    .CNT_LANES_W (BL_W)
  ) u_checker (
    .a1    (a1),
    .a0    (a0),
    .b1    (b1),
    .b0    (b0),
    .y3    (y3),
    .y2    (y2),
    .y1    (y1),
    .y0    (y0),
    .bits  (w_bits),
    .lanes (w_lanes)
  );

  assign w_xfer      = in_valid && (r_state == ACCUM);
  assign w_last_xfer = w_xfer && (r_beat_cnt == CNT_W'(BEATS - 1));
  assign w_start_ok  = start && (r_state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      IDLE:    if (start) w_state_nxt = ACCUM;
      ACCUM: begin
        w_in_ready = 1'b1;
        if (w_last_xfer) w_state_nxt = DRAIN;
      end
      DRAIN:   w_state_nxt = REPORT;
      REPORT: begin
        w_out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_bit_acc_nxt  = r_bit_acc + BIT_W'(r_s1_bits);
  assign w_lane_acc_nxt = r_lane_acc + LANE_W'(r_s1_lanes);

  // Stage 1 carries zero on bubbles, so stage 2 can add unconditionally
  // throughout ACCUM and DRAIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_cnt <= '0;
      r_s1_bits  <= '0;
      r_s1_lanes <= '0;
      r_bit_acc  <= '0;
      r_lane_acc <= '0;
      r_perfect  <= 1'b0;
    end else if (w_start_ok) begin
      r_beat_cnt <= '0;
      r_s1_bits  <= '0;
      r_s1_lanes <= '0;
      r_bit_acc  <= '0;
      r_lane_acc <= '0;
      r_perfect  <= 1'b0;
    end else begin
      if (w_xfer) r_beat_cnt <= w_last_xfer ? '0 : r_beat_cnt + CNT_W'(1);
      r_s1_bits  <= w_xfer ? w_bits : '0;
      r_s1_lanes <= w_xfer ? w_lanes : '0;
      if (r_state == ACCUM || r_state == DRAIN) begin
        r_bit_acc  <= w_bit_acc_nxt;
        r_lane_acc <= w_lane_acc_nxt;
        r_perfect  <= (w_bit_acc_nxt == PERFECT_SCORE);
      end
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = w_out_valid;
  assign busy       = (r_state != IDLE);
  assign bit_score  = r_bit_acc;
  assign lane_score = r_lane_acc;
  assign perfect    = r_perfect;
  assign dbg_state  = r_state;

endmodule
